// File: rtl/alu_pkg.sv
// Shared RV32I ALU definitions: opcode enum, data width and a bit-reverse helper.
// Imported by rv32i_alu and alu_shifter.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    // Opcode is {funct7[5], funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < int'(XLEN); i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit logarithmic barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift network by bit-reversing the input and output.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      shamt_i,
    input  logic            dir_i,    // 0 = left, 1 = right
    input  logic            arith_i,  // sign fill on right shifts
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] stage;
    logic            fill;

    always_comb begin
        fill  = arith_i & dir_i & data_i[XLEN-1];
        stage = dir_i ? data_i : bit_reverse(data_i);
        for (int i = 0; i < 5; i++) begin
            if (shamt_i[i]) begin
                stage = (stage >> (2 ** i))
                      | ({XLEN{fill}} & ~({XLEN{1'b1}} >> (2 ** i)));
            end
        end
        result_o = dir_i ? stage : bit_reverse(stage);
    end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU with combinational result and an optional output register.
// Define ALU_OUT_REG_EN to register alu_data_q/alu_zero_q; otherwise they pass through.
module rv32i_alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_data,
    output logic            alu_zero,
    output logic [XLEN-1:0] alu_data_q,
    output logic            alu_zero_q
);

    alu_op_e         op;
    logic [XLEN-1:0] shift_res;
    logic            shift_right;

    assign op          = alu_op_e'(alu_op);
    assign shift_right = (op == ALU_SRL) || (op == ALU_SRA);

    alu_shifter u_shifter (
        .data_i   (operand_a),
        .shamt_i  (operand_b[4:0]),
        .dir_i    (shift_right),
        .arith_i  (op == ALU_SRA),
        .result_o (shift_res)
    );

    always_comb begin
        unique case (op)
            ALU_ADD:  alu_data = operand_a + operand_b;
            ALU_SUB:  alu_data = operand_a - operand_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_data = shift_res;
            ALU_SLT:  alu_data = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_data = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_XOR:  alu_data = operand_a ^ operand_b;
            ALU_OR:   alu_data = operand_a | operand_b;
            ALU_AND:  alu_data = operand_a & operand_b;
            default:  alu_data = '0;
        endcase
    end

    assign alu_zero = (alu_data == '0);

`ifdef ALU_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_data_q <= '0;
            alu_zero_q <= 1'b1;
        end else begin
            alu_data_q <= alu_data;
            alu_zero_q <= alu_zero;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign alu_data_q     = alu_data;
    assign alu_zero_q     = alu_zero;
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: directed vectors, random vectors against a model,
// and the output register / pass-through path (selected by ALU_OUT_REG_EN).
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_data;
    logic        alu_zero;
    logic [31:0] alu_data_q;
    logic        alu_zero_q;

    int errors = 0;
    int checks = 0;

    rv32i_alu dut (
        .clk        (clk),
        .rst        (rst),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_op     (alu_op),
        .alu_data   (alu_data),
        .alu_zero   (alu_zero),
        .alu_data_q (alu_data_q),
        .alu_zero_q (alu_zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model written straight from the opcode table.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return 32'($signed(a) >>> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Drive at negedge, check combinational outputs, then check the post-edge copy.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        #1;
        check_eq({tag, ".data"}, alu_data, exp);
        check_eq({tag, ".zero"}, {31'b0, alu_zero}, {31'b0, exp == 32'h0});
        @(posedge clk);
        #1;
        check_eq({tag, ".data_q"}, alu_data_q, exp);
        check_eq({tag, ".zero_q"}, {31'b0, alu_zero_q}, {31'b0, exp == 32'h0});
    endtask

    typedef struct {
        string       tag;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir_vecs[$];

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        alu_op    = 4'b0000;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.data_q", alu_data_q, 32'h0);
        check_eq("reset.zero_q", {31'b0, alu_zero_q}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        dir_vecs.push_back('{"add_wrap",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        dir_vecs.push_back('{"sub_wrap",  4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        dir_vecs.push_back('{"slt_neg",   4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        dir_vecs.push_back('{"sltu_big",  4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        dir_vecs.push_back('{"slt_eq",    4'b0010, 32'h80000000, 32'h80000000, 32'h00000000});
        dir_vecs.push_back('{"sltu_eq",   4'b0011, 32'h12345678, 32'h12345678, 32'h00000000});
        dir_vecs.push_back('{"sll_31",    4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000});
        dir_vecs.push_back('{"srl_4",     4'b0101, 32'h80000000, 32'h00000004, 32'h08000000});
        dir_vecs.push_back('{"sra_4",     4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000});
        dir_vecs.push_back('{"sll_sh0",   4'b0001, 32'h80000001, 32'hFFFFFFE0, 32'h80000001});
        dir_vecs.push_back('{"srl_sh0",   4'b0101, 32'h80000001, 32'hFFFFFFE0, 32'h80000001});
        dir_vecs.push_back('{"sra_sh0",   4'b1101, 32'h80000001, 32'hFFFFFFE0, 32'h80000001});
        dir_vecs.push_back('{"sra_hi",    4'b1101, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF});
        dir_vecs.push_back('{"xor",       4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00});
        dir_vecs.push_back('{"or",        4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0});
        dir_vecs.push_back('{"and",       4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
        dir_vecs.push_back('{"undef_9",   4'b1001, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        dir_vecs.push_back('{"undef_a",   4'b1010, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        dir_vecs.push_back('{"undef_b",   4'b1011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        dir_vecs.push_back('{"undef_c",   4'b1100, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        dir_vecs.push_back('{"undef_e",   4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});
        dir_vecs.push_back('{"undef_f",   4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000});

        foreach (dir_vecs[i]) begin
            run_vec(dir_vecs[i].tag, dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b,
                    dir_vecs[i].exp);
        end

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) rb = {27'($urandom), 5'd0};
            run_vec("rand", rop, ra, rb, ref_alu(rop, ra, rb));
        end

        // Output register: capture 5+3, then reset while the comb result still shows 8.
        run_vec("reg_add", 4'b0000, 32'd5, 32'd3, 32'd8);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid.data", alu_data, 32'd8);
`ifdef ALU_OUT_REG_EN
        check_eq("rst_mid.data_q", alu_data_q, 32'h0);
        check_eq("rst_mid.zero_q", {31'b0, alu_zero_q}, 32'h1);
`else
        check_eq("rst_mid.data_q", alu_data_q, 32'd8);
        check_eq("rst_mid.zero_q", {31'b0, alu_zero_q}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_rel.data_q", alu_data_q, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
